// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, a direct-mapped BTB and a one-entry
// fetch buffer that presents IF_* values to the IF/ID register over a req/ack port.
module if_fetch_unit #(
    parameter int unsigned BTB_ENTRIES = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'hB000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    input  logic        btb_wr_en,
    input  logic        btb_wr_taken,
    input  logic [15:0] btb_wr_pc,
    input  logic [15:0] btb_wr_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] IF_instr,
    output logic [15:0] IF_pc_plus_one,
    output logic        IF_branch_was_taken,
    output logic        fetch_busy
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] fb_instr;
    logic [15:0] fb_pc_plus_one;
    logic        fb_taken;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [15:0]            btb_tag    [BTB_ENTRIES];
    logic [15:0]            btb_target [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             hit;
    logic             consume;
    logic [15:0]      pc_plus_one;
    logic [15:0]      next_pc;

    // Prediction on the current PC; the BTB is read before this edge's write lands.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        rd_idx      = pc[IDX_W-1:0];
        hit         = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc);
        pc_plus_one = pc + 16'd1;
        next_pc     = hit ? btb_target[rd_idx] : pc_plus_one;
    end

    assign wr_idx   = btb_wr_pc[IDX_W-1:0];
    assign consume  = ~stall & ~flush;
    assign imem_req = ~rst & ~flush & ((state == ST_FETCH) | ((state == ST_FULL) & consume));

    assign imem_addr           = pc;
    assign IF_instr            = fb_instr;
    assign IF_pc_plus_one      = fb_pc_plus_one;
    assign IF_branch_was_taken = fb_taken;
    assign fetch_busy          = (state == ST_FETCH);

    // The buffer registers hold NOP/0/0 whenever empty, so IF_* come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            fb_instr       <= NOP_INSTR;
            fb_pc_plus_one <= 16'h0000;
            fb_taken       <= 1'b0;
        end else if (flush) begin
            state          <= ST_FETCH;
            pc             <= redirect_pc;
            fb_instr       <= NOP_INSTR;
            fb_pc_plus_one <= 16'h0000;
            fb_taken       <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        fb_instr       <= imem_rdata;
                        fb_pc_plus_one <= pc_plus_one;
                        fb_taken       <= hit;
                        pc             <= next_pc;
                        state          <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        if (imem_ack) begin
                            fb_instr       <= imem_rdata;
                            fb_pc_plus_one <= pc_plus_one;
                            fb_taken       <= hit;
                            pc             <= next_pc;
                        end else begin
                            // Request stays up at the same PC, so it is never withdrawn unacked.
                            fb_instr       <= NOP_INSTR;
                            fb_pc_plus_one <= 16'h0000;
                            fb_taken       <= 1'b0;
                            state          <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (btb_wr_en) begin
            if (btb_wr_taken) begin
                btb_valid[wr_idx] <= 1'b1;
            end else if (btb_valid[wr_idx] && (btb_tag[wr_idx] == btb_wr_pc)) begin
                btb_valid[wr_idx] <= 1'b0;
            end
        end
    end

    // NOTE: tag and target are qualified by the valid bit, so they stay unreset plain storage.
    always_ff @(posedge clk) begin
        if (btb_wr_en && btb_wr_taken) begin
            btb_tag[wr_idx]    <= btb_wr_pc;
            btb_target[wr_idx] <= btb_wr_target;
        end
    end

endmodule
